// File: rtl/elbeth_mux4b_arbiter_pkg.sv
// Shared definitions for the two-port nibble arbiter: FSM state encoding and
// reset value of the mux select.
package elbeth_mux4b_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN1 = 2'b01,
    OWN2 = 2'b10
  } arb_state_t;

  // mux_sel = 1 routes data_1 through the shared path
  localparam logic MUX_SEL_RST = 1'b1;

endpackage

// File: rtl/elbeth_mux4b_arbiter_mux.sv
// Two-input 4-bit multiplexer; bit_select = 1 passes mux_in_1.
module elbeth_mux4b_2_to_1 (
  input  logic [3:0] mux_in_1,
  input  logic [3:0] mux_in_2,
  input  logic       bit_select,
  output logic [3:0] mux_out
);

  assign mux_out = bit_select ? mux_in_1 : mux_in_2;

endmodule

// File: rtl/elbeth_mux4b_arbiter.sv
// Round-robin arbiter sharing one nibble path between two producers, with a
// burst limit and a one-entry valid/ready output stage.
module elbeth_mux4b_arbiter
  import elbeth_mux4b_arbiter_pkg::*;
#(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_1,
  input  logic [3:0] data_1,
  output logic       ack_1,
  input  logic       req_2,
  input  logic [3:0] data_2,
  output logic       ack_2,
  output logic       grant_1,
  output logic       grant_2,
  output logic       mux_sel,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready
);

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0] BURST_SAT  = CNT_W'(BURST_MAX);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic             rr_pref2, rr_nxt;
  logic             sel_nxt;
  logic [3:0]       mux_out;
  logic             free;
  logic             any_ack;

  elbeth_mux4b_2_to_1 u_mux (
    .mux_in_1  (data_1),
    .mux_in_2  (data_2),
    .bit_select(mux_sel),
    .mux_out   (mux_out)
  );

  assign grant_1 = (state == OWN1);
  assign grant_2 = (state == OWN2);
  assign free    = ~out_valid | out_ready;
  assign ack_1   = grant_1 & req_1 & free;
  assign ack_2   = grant_2 & req_2 & free;
  assign any_ack = ack_1 | ack_2;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    rr_nxt    = rr_pref2;
    sel_nxt   = mux_sel;
    case (state)
      IDLE: begin
        if (req_1 && (!req_2 || !rr_pref2)) state_nxt = OWN1;
        else if (req_2)                     state_nxt = OWN2;
      end
      OWN1: begin
        if (!req_1)                                        state_nxt = req_2 ? OWN2 : IDLE;
        else if (ack_1 && req_2 && burst_cnt >= BURST_LAST) state_nxt = OWN2;
      end
      OWN2: begin
        if (!req_2)                                        state_nxt = req_1 ? OWN1 : IDLE;
        else if (ack_2 && req_1 && burst_cnt >= BURST_LAST) state_nxt = OWN1;
      end
      default: state_nxt = IDLE;
    endcase
    // Any grant change restarts the burst; entering IDLE leaves select and pointer as they were
    if (state_nxt != state) begin
      burst_nxt = '0;
      if (state_nxt == OWN1) begin
        rr_nxt  = 1'b1;
        sel_nxt = 1'b1;
      end else if (state_nxt == OWN2) begin
        rr_nxt  = 1'b0;
        sel_nxt = 1'b0;
      end
    end else if (any_ack && burst_cnt != BURST_SAT) begin
      burst_nxt = burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      rr_pref2  <= 1'b0;
      mux_sel   <= MUX_SEL_RST;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      rr_pref2  <= rr_nxt;
      mux_sel   <= sel_nxt;
      if (any_ack) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_mux4b_arbiter.sv
// Randomized and directed bench for elbeth_mux4b_arbiter against a
// transaction-level reference model.
module tb_elbeth_mux4b_arbiter;

  localparam int BURST_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_1 = 1'b0, req_2 = 1'b0, out_ready = 1'b0;
  logic [3:0] data_1 = '0, data_2 = '0;
  logic       ack_1, ack_2, grant_1, grant_2, mux_sel, out_valid;
  logic [3:0] out_data;

  elbeth_mux4b_arbiter #(.BURST_MAX(BURST_MAX), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_1(req_1), .data_1(data_1), .ack_1(ack_1),
    .req_2(req_2), .data_2(data_2), .ack_2(ack_2),
    .grant_1(grant_1), .grant_2(grant_2), .mux_sel(mux_sel),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = nobody, 1/2 = port; pref = port favoured on a tie
  bit       m_known = 0;
  int       m_owner, m_acks, m_pref;
  bit       m_sel, m_vld;
  bit [3:0] m_data;
  bit       la1, la2;

  // Producer state used by the random phase
  bit       p1, p2;
  bit [3:0] pd1, pd2;

  task automatic step(input bit rn, input bit r1, input bit [3:0] d1,
                      input bit r2, input bit [3:0] d2, input bit rdy);
    bit e1, e2, other_req, own_req;
    int nxt, other;
    @(negedge clk);
    rst_n = rn; req_1 = r1; data_1 = d1; req_2 = r2; data_2 = d2; out_ready = rdy;
    #1;
    e1 = (m_owner == 1) && r1 && (!m_vld || rdy);
    e2 = (m_owner == 2) && r2 && (!m_vld || rdy);
    la1 = e1; la2 = e2;
    if (m_known) begin
      check("grant_1",   {3'b0, grant_1},   {3'b0, m_owner == 1});
      check("grant_2",   {3'b0, grant_2},   {3'b0, m_owner == 2});
      check("mux_sel",   {3'b0, mux_sel},   {3'b0, m_sel});
      check("out_valid", {3'b0, out_valid}, {3'b0, m_vld});
      check("out_data",  out_data,          m_data);
      check("ack_1",     {3'b0, ack_1},     {3'b0, e1});
      check("ack_2",     {3'b0, ack_2},     {3'b0, e2});
      check("ack_excl",  {3'b0, ack_1 & ack_2}, 4'h0);
    end
    if (!rn) begin
      m_known = 1; m_owner = 0; m_acks = 0; m_pref = 1;
      m_sel = 1; m_vld = 0; m_data = 0;
      return;
    end
    if (!m_known) return;
    if (e1 || e2) begin
      m_data = e1 ? d1 : d2;
      m_vld  = 1;
    end else if (rdy) begin
      m_vld = 0;
    end
    other     = 3 - m_owner;
    own_req   = (m_owner == 1) ? r1 : r2;
    other_req = (m_owner == 1) ? r2 : r1;
    nxt = m_owner;
    if (m_owner == 0) begin
      if (r1 && r2)  nxt = m_pref;
      else if (r1)   nxt = 1;
      else if (r2)   nxt = 2;
    end else if (!own_req) begin
      nxt = other_req ? other : 0;
    end else if ((e1 || e2) && other_req && m_acks + 1 >= BURST_MAX) begin
      nxt = other;
    end
    if (nxt != m_owner) begin
      m_acks = 0;
      if (nxt != 0) begin
        m_pref = 3 - nxt;
        m_sel  = (nxt == 1);
      end
    end else if ((e1 || e2) && m_acks < BURST_MAX) begin
      m_acks++;
    end
    m_owner = nxt;
  endtask

  initial begin
    // Reset held with req_1 high, then grant_1 one cycle after release
    step(0, 1, 4'h3, 0, 4'h0, 1);
    step(0, 1, 4'h3, 0, 4'h0, 1);
    step(1, 1, 4'h3, 0, 4'h0, 1);
    step(1, 1, 4'h3, 0, 4'h0, 1);
    check("grant_1_rise", {3'b0, grant_1}, 4'h1);
    step(1, 0, 4'h3, 0, 4'h0, 1);
    step(1, 0, 4'h0, 0, 4'h0, 1);

    // Single port 2 streaming at full rate
    for (int i = 0; i < 6; i++) step(1, 0, 4'h0, 1, 4'hA, 1);
    check("single_out", out_data, 4'hA);
    step(1, 0, 4'h0, 0, 4'h0, 1);

    // Contention from IDLE after reset
    step(0, 0, 4'h0, 0, 4'h0, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 4'(i), 1, 4'(15 - i), 1);

    // Backpressure on port 2, then drain and reload in the same cycle
    step(0, 0, 4'h0, 0, 4'h0, 1);
    step(1, 0, 4'h0, 1, 4'h6, 1);
    step(1, 0, 4'h0, 1, 4'h6, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 4'h0, 1, 4'h9, 0);
    check("bp_hold", out_data, 4'h6);
    step(1, 0, 4'h0, 1, 4'h9, 1);
    step(1, 0, 4'h0, 0, 4'h0, 1);
    check("bp_reload", out_data, 4'h9);

    // Early release by port 1 after two acks while port 2 waits
    step(0, 0, 4'h0, 0, 4'h0, 1);
    step(1, 1, 4'h1, 1, 4'h8, 1);
    step(1, 1, 4'h1, 1, 4'h8, 1);
    step(1, 1, 4'h2, 1, 4'h8, 1);
    step(1, 0, 4'h0, 1, 4'h8, 1);
    for (int i = 0; i < 6; i++) step(1, 1, 4'h5, 1, 4'(i), 1);

    // Reset during OWN2 with a nibble held, then tie goes to port 1
    step(1, 0, 4'h0, 1, 4'hC, 0);
    step(1, 0, 4'h0, 1, 4'hC, 0);
    step(1, 0, 4'h0, 1, 4'hC, 0);
    step(0, 0, 4'h0, 1, 4'hC, 0);
    step(1, 1, 4'h4, 1, 4'hC, 1);
    step(1, 1, 4'h4, 1, 4'hC, 1);

    // Random traffic with protocol-respecting producers
    p1 = 0; p2 = 0; pd1 = 0; pd2 = 0;
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 97) != 0, p1, pd1, p2, pd2, ($urandom % 4) != 0);
      if (p1 && la1) begin
        if ($urandom % 3 == 0) p1 = 0; else pd1 = 4'($urandom);
      end else if (!p1 && ($urandom % 2 == 1)) begin
        p1 = 1; pd1 = 4'($urandom);
      end
      if (p2 && la2) begin
        if ($urandom % 3 == 0) p2 = 0; else pd2 = 4'($urandom);
      end else if (!p2 && ($urandom % 2 == 1)) begin
        p2 = 1; pd2 = 4'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
